// File: rtl/d_latch.sv
// Level-enabled hold register with a latch-like interface, built entirely from flip-flops.
// While e is high, q either passes d straight through (TRANSPARENT=1) or picks it up on
// the next clk edge (TRANSPARENT=0). While e is low, q holds the last value captured.
// qbar always mirrors ~q, and loaded reports whether any capture has happened since reset.
module d_latch #(
  parameter int unsigned      WIDTH       = 1,
  parameter bit               TRANSPARENT = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             e,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             loaded
);

  logic [WIDTH-1:0] hold_q;
  logic             loaded_q;
  logic [WIDTH-1:0] q_int;

  // Capture d on every clk edge where e is high; any reset throws away the held value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= RESET_VAL;
      loaded_q <= 1'b0;
    end else if (e) begin
      hold_q   <= d;
      loaded_q <= 1'b1;
    end
  end

  // Output select. An asserted reset overrides the transparent bypass, so q never shows d
  // while the block is held in reset.
  always_comb begin
    q_int = hold_q;
    if (TRANSPARENT && e) begin
      q_int = d;
    end
    if (!rst_n) begin
      q_int = RESET_VAL;
    end
  end

  assign q      = q_int;
  assign qbar   = ~q_int;
  assign loaded = loaded_q;

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch, with three instances:
//   u_t1 : WIDTH=1, TRANSPARENT=1
//   u_t0 : WIDTH=8, TRANSPARENT=0
//   u_rv : WIDTH=8, TRANSPARENT=0, RESET_VAL=8'h3C
module tb_d_latch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       e0 = 1'b0;
  logic [0:0] d0 = '0;
  logic [0:0] q0;
  logic [0:0] qb0;
  logic       ld0;

  logic       e1 = 1'b0;
  logic [7:0] d1 = '0;
  logic [7:0] q1;
  logic [7:0] qb1;
  logic       ld1;

  logic       e2 = 1'b0;
  logic [7:0] d2 = '0;
  logic [7:0] q2;
  logic [7:0] qb2;
  logic       ld2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  d_latch #(
    .WIDTH      (1),
    .TRANSPARENT(1'b1),
    .RESET_VAL  (1'b0)
  ) u_t1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d0),
    .e     (e0),
    .q     (q0),
    .qbar  (qb0),
    .loaded(ld0)
  );

  d_latch #(
    .WIDTH      (8),
    .TRANSPARENT(1'b0),
    .RESET_VAL  (8'h00)
  ) u_t0 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d1),
    .e     (e1),
    .q     (q1),
    .qbar  (qb1),
    .loaded(ld1)
  );

  d_latch #(
    .WIDTH      (8),
    .TRANSPARENT(1'b0),
    .RESET_VAL  (8'h3C)
  ) u_rv (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d2),
    .e     (e2),
    .q     (q2),
    .qbar  (qb2),
    .loaded(ld2)
  );

  typedef struct {
    int unsigned dut;
    logic        e;
    logic [7:0]  d;
    logic [7:0]  q_now;    // q shortly after the inputs are applied, before the next edge
    logic [7:0]  q_after;  // q just after the following rising edge
    logic        ld_after;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int unsigned dut, input logic e, input logic [7:0] d,
                              input logic [7:0] q_now, input logic [7:0] q_after,
                              input logic ld_after);
    vec_t v;
    v.dut      = dut;
    v.e        = e;
    v.d        = d;
    v.q_now    = q_now;
    v.q_after  = q_after;
    v.ld_after = ld_after;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int unsigned dut, input logic e, input logic [7:0] d);
    case (dut)
      0: begin e0 = e; d0 = d[0:0]; end
      1: begin e1 = e; d1 = d; end
      default: begin e2 = e; d2 = d; end
    endcase
  endtask

  task automatic read(input int unsigned dut, output logic [7:0] q, output logic [7:0] qb,
                      output logic ld);
    case (dut)
      0: begin q = {7'd0, q0}; qb = {7'd0, qb0}; ld = ld0; end
      1: begin q = q1; qb = qb1; ld = ld1; end
      default: begin q = q2; qb = qb2; ld = ld2; end
    endcase
  endtask

  // Expected qbar for a given expected q, confined to the instance width.
  function automatic logic [7:0] inv(input int unsigned dut, input logic [7:0] v);
    return (dut == 0) ? (~v & 8'h01) : ~v;
  endfunction

  initial begin
    logic [7:0] q, qb;
    logic       ld;
    logic [7:0] exp_hold;

    // WIDTH=1, TRANSPARENT=1, starting from reset.
    vecs.push_back(mk(0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0)); // still 0 after release, e=0
    vecs.push_back(mk(0, 1'b1, 8'h01, 8'h01, 8'h01, 1'b1));
    vecs.push_back(mk(0, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1));
    vecs.push_back(mk(0, 1'b0, 8'h01, 8'h01, 8'h01, 1'b1));
    vecs.push_back(mk(0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1)); // zero-latency follow
    vecs.push_back(mk(0, 1'b1, 8'h01, 8'h01, 8'h01, 1'b1));
    vecs.push_back(mk(0, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1));
    // WIDTH=8, TRANSPARENT=0, starting from reset.
    vecs.push_back(mk(1, 1'b1, 8'hA5, 8'h00, 8'hA5, 1'b1)); // visible only after the edge
    vecs.push_back(mk(1, 1'b0, 8'hFF, 8'hA5, 8'hA5, 1'b1));
    vecs.push_back(mk(1, 1'b1, 8'h3C, 8'hA5, 8'h3C, 1'b1));
    vecs.push_back(mk(1, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b1));

    // Reset with RESET_VAL=8'h3C, enable and data active while reset is held.
    e2 = 1'b1;
    d2 = 8'hFF;
    e0 = 1'b1;
    d0 = 1'b1;
    #12;
    check("rv_q_in_reset", q2, 8'h3C);
    check("rv_qbar_in_reset", qb2, 8'hC3);
    check("rv_loaded_in_reset", {7'd0, ld2}, 8'h00);
    check("t1_q_reset_dominates", {7'd0, q0}, 8'h00);
    check("t1_qbar_in_reset", {7'd0, qb0}, 8'h01);
    check("t1_loaded_in_reset", {7'd0, ld0}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    e2 = 1'b0;
    e0 = 1'b0;
    @(posedge clk);
    #1;
    check("rv_q_after_release", q2, 8'h3C);
    @(negedge clk);
    e2 = 1'b1;
    d2 = 8'h00;
    @(posedge clk);
    #1;
    check("rv_first_capture_q", q2, 8'h00);
    check("rv_first_capture_qbar", qb2, 8'hFF);
    check("rv_first_capture_loaded", {7'd0, ld2}, 8'h01);
    e2 = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].dut, vecs[i].e, vecs[i].d);
      #1;
      read(vecs[i].dut, q, qb, ld);
      check($sformatf("vec%0d_q_now", i), q, vecs[i].q_now);
      check($sformatf("vec%0d_qbar_now", i), qb, inv(vecs[i].dut, vecs[i].q_now));
      @(posedge clk);
      #1;
      read(vecs[i].dut, q, qb, ld);
      check($sformatf("vec%0d_q_after", i), q, vecs[i].q_after);
      check($sformatf("vec%0d_qbar_after", i), qb, inv(vecs[i].dut, vecs[i].q_after));
      check($sformatf("vec%0d_loaded", i), {7'd0, ld}, {7'd0, vecs[i].ld_after});
    end

    // Enable toggling on the registered 8-bit instance: only even cycles capture.
    exp_hold = q1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e1 = (i % 2 == 0);
      d1 = 8'(i);
      if (i % 2 == 0) exp_hold = 8'(i);
      @(posedge clk);
      #1;
      check($sformatf("toggle%0d_q", i), q1, exp_hold);
      check($sformatf("toggle%0d_qbar", i), qb1, ~exp_hold);
    end
    e1 = 1'b0;

    // Asynchronous reset between edges while u_t1 holds 1 with e=0.
    @(posedge clk);
    #1;
    check("t1_holding_one", {7'd0, q0}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_t1_q", {7'd0, q0}, 8'h00);
    check("async_t1_qbar", {7'd0, qb0}, 8'h01);
    check("async_t1_loaded", {7'd0, ld0}, 8'h00);
    check("async_t0_q", q1, 8'h00);
    check("async_rv_q", q2, 8'h3C);

    // Reset dominates transparency, then q waits for a real capture after release.
    e0 = 1'b1;
    d0 = 1'b1;
    #1;
    check("t1_reset_dominates_e", {7'd0, q0}, 8'h00);
    @(posedge clk);
    #1;
    check("t1_no_capture_in_reset", {7'd0, q0}, 8'h00);
    check("t1_loaded_stays_low", {7'd0, ld0}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    e0 = 1'b0;
    @(posedge clk);
    #1;
    check("t1_release_e0_q", {7'd0, q0}, 8'h00);
    check("t1_release_e0_loaded", {7'd0, ld0}, 8'h00);
    @(negedge clk);
    e0 = 1'b1;
    #1;
    check("t1_transparent_after_release", {7'd0, q0}, 8'h01);
    @(posedge clk);
    #1;
    check("t1_loaded_after_capture", {7'd0, ld0}, 8'h01);
    @(negedge clk);
    e0 = 1'b0;
    d0 = 1'b0;
    #1;
    check("t1_hold_after_capture", {7'd0, q0}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
